// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  // Iteration counter width for a given operand width.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: radix-2 shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               bit_in,
  input  logic               mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           ge;

  // Divide keeps {remainder, quotient} in acc; the next dividend bit enters
  // the remainder from bit_in. A magnitude compare (not trial's MSB) decides
  // the quotient bit so that a zero divisor still shifts the dividend through.
  always_comb begin
    shifted  = {acc[2*WIDTH-1:WIDTH], bit_in};
    trial    = shifted - {1'b0, operand};
    ge       = (shifted >= {1'b0, operand});
    acc_next = '0;
    if (mode) begin
      if (ge) acc_next = {trial[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
      else    acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, (bit_in ? operand : {WIDTH{1'b0}})};
    end
  end

endmodule

// File: rtl/muldiv.sv
// Iterative mult/multu/div/divu unit owning the HI/LO registers.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state;
  logic [1:0]           op_r;
  logic                 neg_a, neg_b, dz;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [WIDTH-1:0]     opd, sh;

  logic                 sgn, is_div;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  // A zero divisor keeps a raw so the remainder comes out as a unmodified.
  always_comb begin
    sgn    = ~op[0];
    is_div = op[1];
    mag_a  = (sgn && a[WIDTH-1] && !(is_div && b == '0)) ? -a : a;
    mag_b  = (sgn && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    quo  = (!dz && (neg_a ^ neg_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = (!dz && neg_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opd),
    .bit_in   (sh[WIDTH-1]),
    .mode     (op_r[1]),
    .acc_next (acc_next)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      op_r  <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      dz    <= 1'b0;
      count <= '0;
      acc   <= '0;
      opd   <= '0;
      sh    <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wd;
          if (lo_we) lo <= wd;
          if (start) begin
            op_r  <= op;
            neg_a <= sgn & a[WIDTH-1];
            neg_b <= sgn & b[WIDTH-1];
            dz    <= (b == '0);
            opd   <= is_div ? mag_b : mag_a;
            sh    <= is_div ? mag_a : mag_b;
            acc   <= '0;
            count <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          sh    <= {sh[WIDTH-2:0], 1'b0};
          count <= count + 1'b1;
          if (count == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (op_r[1]) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: stimulus pushes expected hi/lo and done cycle.
module tb_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 0, reset = 0, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0]   op = 0;
  logic [W-1:0] a = 0, b = 0, wd = 0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           at;
    string        name;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done at cycle %0d want none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_at"}, W'(cyc), W'(e.at));
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge (E0) and done is
  // visible at the negedge following E0+33.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input string name);
    op = o; a = x; b = y; start = 1;
    sb.push_back('{hi: ehi, lo: elo, at: cyc + 34, name: name});
    @(negedge clk);
    start = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1;
    @(negedge clk);

    // Latency and busy width on the first operation.
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", W'(n), 33);
    chk("done_with_idle", W'(done), 1);
    drain();

    issue(MD_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5");
    drain();
    issue(MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, "mult_minsq");
    drain();
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
    drain();
    issue(MD_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, "divu_by0");
    drain();
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf");
    drain();
    issue(MD_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_neg_by0");
    drain();
    issue(MD_MULTU, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, "multu_shift");
    drain();

    // Back-to-back: next start in the done cycle.
    issue(MD_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, "mult_7xneg6");
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    issue(MD_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7byneg2");
    drain();

    // Start and mthi while busy are ignored.
    issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100by7");
    repeat (5) @(negedge clk);
    op = MD_DIVU; a = 32'd9; b = 32'd3; start = 1; hi_we = 1; wd = 32'h1234;
    @(negedge clk);
    start = 0; hi_we = 0;
    drain();
    chk("busy_we_hi", hi, 32'd2);
    chk("busy_we_lo", lo, 32'd14);

    hi_we = 1; wd = 32'h1234;
    @(negedge clk);
    hi_we = 0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'd14);
    hi_we = 1; lo_we = 1; wd = 32'hAAAA5555;
    @(negedge clk);
    hi_we = 0; lo_we = 0;
    chk("both_we_hi", hi, 32'hAAAA5555);
    chk("both_we_lo", lo, 32'hAAAA5555);

    // Asynchronous reset mid-operation discards the result.
    issue(MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, "discarded");
    repeat (9) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("midrst_busy", W'(busy), 0);
    chk("midrst_done", W'(done), 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    sb.delete();
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Fresh start after reset, with mtlo on the start edge.
    lo_we = 1; wd = 32'h55;
    issue(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "post_rst");
    lo_we = 0;
    chk("start_mtlo", lo, 32'h55);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
